// File: rtl/issue_q_pkg.sv
// Shared types and constants for the dual-ported instruction issue queue.
package issue_q_pkg;

    localparam int DATA_W    = 64;
    localparam int PC_MSB    = 63;
    localparam int PC_LSB    = 32;
    localparam int INSTR_MSB = 31;
    localparam int INSTR_LSB = 0;

    typedef enum logic [1:0] {
        DEQ_NONE = 2'b00,
        DEQ_ONE  = 2'b01,
        DEQ_TWO  = 2'b11
    } deq_code_e;

    typedef struct packed {
        logic [PC_MSB-PC_LSB:0]       pc;
        logic [INSTR_MSB-INSTR_LSB:0] instr;
    } bundle_t;

endpackage

// File: rtl/iq_storage.sv
// Entry array for the issue queue: two write ports at consecutive slots and
// two asynchronous read ports for the head pair.
module iq_storage #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we1,
    input  logic             we2,
    input  logic [AW-1:0]    waddr1,
    input  logic [AW-1:0]    waddr2,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [WIDTH-1:0] wdata2,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // waddr1 and waddr2 are always distinct, so the two writes never collide.
    always_ff @(posedge clk) begin
        if (we1) mem_reg[waddr1] <= wdata1;
        if (we2) mem_reg[waddr2] <= wdata2;
    end

    assign rdata1 = mem_reg[raddr1];
    assign rdata2 = mem_reg[raddr2];

endmodule

// File: rtl/instr_issue_queue.sv
// Circular issue queue: fetch pushes up to two bundles per cycle, the
// scheduler pops up to two from the head. All outputs come from registered state.
module instr_issue_queue
    import issue_q_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = issue_q_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        enq_data1_i,
    input  logic [DATA_W-1:0]        enq_data2_i,
    input  logic                     enq_valid1_i,
    input  logic                     enq_valid2_i,
    output logic                     enq_ready_o,
    output logic [DATA_W-1:0]        fifo_out1_o,
    output logic [DATA_W-1:0]        fifo_out2_o,
    output logic                     fifo_valid1_o,
    output logic                     fifo_valid2_o,
    output logic                     fifo_empty_o,
    input  logic [1:0]               dequeue_en_i,
    input  logic                     fifo_stall_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     underflow_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              underflow_reg, underflow_next;
    logic [CW-1:0]     enq_n, deq_req, deq_n;
    logic              enq_ready;
    logic [DATA_W-1:0] rdata1, rdata2;

    always_comb begin
        // Readiness looks at current occupancy only; a same-cycle pop earns no credit.
        enq_ready = (count_reg <= CW'(DEPTH - 2));

        enq_n = '0;
        if (enq_ready && enq_valid1_i) begin
            enq_n = enq_valid2_i ? CW'(2) : CW'(1);
        end

        deq_req = '0;
        if (!fifo_stall_i) begin
            case (dequeue_en_i)
                DEQ_ONE: deq_req = CW'(1);
                DEQ_TWO: deq_req = CW'(2);
                default: deq_req = '0;
            endcase
        end
        deq_n = (deq_req > count_reg) ? count_reg : deq_req;

        if (flush_i) begin
            rd_ptr_next    = '0;
            wr_ptr_next    = '0;
            count_next     = '0;
            underflow_next = underflow_reg;
        end else begin
            rd_ptr_next    = rd_ptr_reg + deq_n[AW-1:0];
            wr_ptr_next    = wr_ptr_reg + enq_n[AW-1:0];
            count_next     = count_reg + enq_n - deq_n;
            underflow_next = underflow_reg | (deq_req > count_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            underflow_reg <= underflow_next;
        end
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_storage (
        .clk    (clk),
        .we1    ((enq_n != '0) && !flush_i),
        .we2    ((enq_n == CW'(2)) && !flush_i),
        .waddr1 (wr_ptr_reg),
        .waddr2 (wr_ptr_reg + AW'(1)),
        .wdata1 (enq_data1_i),
        .wdata2 (enq_data2_i),
        .raddr1 (rd_ptr_reg),
        .raddr2 (rd_ptr_reg + AW'(1)),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign enq_ready_o     = enq_ready;
    assign fifo_valid1_o   = (count_reg != '0);
    assign fifo_valid2_o   = (count_reg >= CW'(2));
    assign fifo_empty_o    = (count_reg == '0);
    assign fifo_out1_o     = fifo_valid1_o ? rdata1 : '0;
    assign fifo_out2_o     = fifo_valid2_o ? rdata2 : '0;
    assign count_o         = count_reg;
    assign underflow_err_o = underflow_reg;

endmodule

// File: doc/instr_issue_queue.md
# instr_issue_queue

Dual-ported circular instruction queue between fetch/decode and the dual-issue scheduler. Fetch enqueues up to two {PC, instruction} bundles per cycle. The scheduler sees the two oldest entries and removes 0, 1 or 2 of them each cycle through its dequeue request. The queue also supplies the valid/empty flags the scheduler uses for issue and stall decisions.

## Interface
Parameters:
- DEPTH, 16, entry count; power of two, >= 4
- DATA_W, 64, bundle width: PC in [63:32], instruction in [31:0]

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- enq_data1_i  input  DATA_W  older incoming bundle
- enq_data2_i  input  DATA_W  younger incoming bundle
- enq_valid1_i  input  1  write enq_data1_i
- enq_valid2_i  input  1  write enq_data2_i; honoured only together with enq_valid1_i
- enq_ready_o  output  1  at least 2 free entries
- fifo_out1_o  output  DATA_W  oldest entry; 0 when fifo_valid1_o low
- fifo_out2_o  output  DATA_W  second-oldest entry; 0 when fifo_valid2_o low
- fifo_valid1_o  output  1  count >= 1
- fifo_valid2_o  output  1  count >= 2
- fifo_empty_o  output  1  count == 0
- dequeue_en_i  input  2  2'b00 none, 2'b01 one, 2'b11 two, 2'b10 reserved (treated as none)
- fifo_stall_i  input  1  scheduler stall; forces dequeue to none
- flush_i  input  1  discard all contents
- count_o  output  $clog2(DEPTH)+1  occupancy
- underflow_err_o  output  1  sticky: dequeue requested beyond valid entries

## Operation
- State: storage array, rd_ptr and wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- Enqueue: accepted only if enq_ready_o is high in that cycle.
  - enq_valid1_i alone writes data1 at wr_ptr; wr_ptr += 1.
  - Both valids write data1 at wr_ptr and data2 at wr_ptr+1; wr_ptr += 2.
  - enq_valid2_i without enq_valid1_i is ignored.
  - Enqueue while enq_ready_o is low is dropped; fetch must hold its data.
- Dequeue count d:
  - 0 if fifo_stall_i is high or the code is 00/10.
  - Otherwise 1 for 01 and 2 for 11.
  - d is clamped to the current count. Clamping sets underflow_err_o, which stays set until rst.
  - rd_ptr += d.
- Simultaneous enqueue and dequeue are legal. count_next = count + enq_n - d.
- enq_ready_o is computed from the current count only. There is no credit for a same-cycle dequeue.
- flush_i takes priority over enqueue and dequeue in the same cycle. Next cycle: rd_ptr = wr_ptr = 0, count = 0, and that cycle's enqueue is discarded. underflow_err_o is unaffected.
- Read outputs:
  - Slot 1 reads storage[rd_ptr]; slot 2 reads storage[rd_ptr+1 mod DEPTH].
  - Both are masked to 0 when invalid.
  - They depend on registered state only; there is no combinational path from any input.

## Timing
- Reset values: count_o = 0, fifo_empty_o = 1, fifo_valid1_o = fifo_valid2_o = 0, fifo_out1_o = fifo_out2_o = 0, enq_ready_o = 1, underflow_err_o = 0. Storage is not reset.
- Enqueue latency: a bundle accepted in cycle N is visible at the queue head in cycle N+1 if the queue was empty. There is no bypass.
- Dequeue takes effect at the edge. The next entries are presented in the following cycle.
- Full condition: count == DEPTH; enq_ready_o is low once count > DEPTH-2.
- Wrap: a pair written at wr_ptr = DEPTH-1 lands in slots DEPTH-1 and 0. The slot-2 read wraps the same way.
- rst asserted mid-operation clears the queue at the next edge, regardless of the other inputs.

## Structure
- Package issue_q_pkg holds:
  - DATA_W and PC/instruction field slices
  - dequeue encodings DEQ_NONE, DEQ_ONE, DEQ_TWO
  - a bundle typedef
- Sub-module iq_storage: DEPTH x DATA_W register array with two write ports (addresses wr_ptr and wr_ptr+1) and two asynchronous read ports. Pointer, count and flag logic stay in instr_issue_queue.

## Test plan
- Reset, then enqueue pairs A/B and C/D in consecutive cycles. Required: count_o = 4; out1 = A, out2 = B. Then dequeue_en_i = 11 -> next cycle out1 = C, out2 = D, count_o = 2.
- Fill 15 entries with DEPTH = 16. Required: enq_ready_o = 0. A pair enqueue is dropped and count_o stays 15. A single dequeue brings count_o to 14 and enq_ready_o back to 1.
- Wrap: cycle the pointers so wr_ptr = 15, then enqueue the pair X/Y. Drain to X. Required: out1 = X, out2 = Y, with Y read from slot 0.
- Dequeue edge cases:
  - With count 1, dequeue_en_i = 11 -> count_o = 0, fifo_empty_o = 1, underflow_err_o = 1 and stays 1.
  - fifo_stall_i = 1 with dequeue_en_i = 01 -> no change.
- Flush: flush_i together with an enqueue of a pair and dequeue_en_i = 01 at count 6. Required next cycle: count_o = 0, fifo_empty_o = 1, outputs 0. A subsequent enqueue of E appears at out1.
- Simultaneous enqueue and dequeue: at count 3, enqueue a pair with dequeue_en_i = 11. Required: count_o = 3, and the head advances by 2.
